// File: rtl/bus_timer_if.sv
// Single-cycle external-bus port of the timer: decoder select, word address, byte-strobed write data, combinational read data.
interface bus_timer_if;
    logic        select;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;

    modport master (
        output select, address, data_in, data_strobes, read, write,
        input  data_out
    );

    modport slave (
        input  select, address, data_in, data_strobes, read, write,
        output data_out
    );
endinterface

// File: rtl/bus_timer.sv
// Prescaled down-counting timer with one-shot/auto-reload modes and a registered irq.
// Reads are zero-latency, writes land at the sampling edge; the bus is never stalled.
module bus_timer #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    bus_timer_if.slave bus,
    output logic       irq
);
    localparam logic [1:0] ADDR_CONTROL  = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_RELOAD   = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    logic                      enable, auto_reload, irq_en, expired;
    logic                      enable_n, auto_reload_n, irq_en_n, expired_n, irq_n;
    logic [PRESCALE_WIDTH-1:0] prescale, pc, prescale_n, pc_n;
    logic [31:0]               reload, count, reload_n, count_n;
    logic                      wr_sel, tick, expire;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        enable_n      = enable;
        auto_reload_n = auto_reload;
        irq_en_n      = irq_en;
        expired_n     = expired;
        prescale_n    = prescale;
        reload_n      = reload;
        count_n       = count;

        wr_sel = bus.select & bus.write;
        tick   = enable && (pc == prescale);
        expire = tick && (count == 32'd0);

        if (tick) begin
            if (count != 32'd0)  count_n  = count - 32'd1;
            else if (auto_reload) count_n = reload;
            else                  enable_n = 1'b0;
        end

        // Set wins over a same-cycle write-1-to-clear.
        if (expire)
            expired_n = 1'b1;
        else if (wr_sel && bus.address == ADDR_CONTROL && bus.data_strobes[1] && bus.data_in[8])
            expired_n = 1'b0;

        // Bus writes are applied last so they override the counting engine.
        if (wr_sel) begin
            case (bus.address)
                ADDR_CONTROL: begin
                    if (bus.data_strobes[0]) begin
                        enable_n      = bus.data_in[0];
                        auto_reload_n = bus.data_in[1];
                        irq_en_n      = bus.data_in[2];
                    end
                end
                ADDR_PRESCALE: begin
                    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
                        if (bus.data_strobes[i/8]) prescale_n[i] = bus.data_in[i];
                    end
                end
                ADDR_RELOAD: reload_n = lane_merge(reload, bus.data_in, bus.data_strobes);
                default: begin
                    if (|bus.data_strobes) count_n = lane_merge(count, bus.data_in, bus.data_strobes);
                end
            endcase
        end

        // pc restarts whenever the timer is (or becomes) stopped, including a 0->1 enable.
        if (!enable || !enable_n || tick) pc_n = '0;
        else                              pc_n = pc + 1'b1;

        irq_n = expired_n & irq_en_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable      <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            expired     <= 1'b0;
            prescale    <= '0;
            pc          <= '0;
            reload      <= 32'd0;
            count       <= 32'd0;
            irq         <= 1'b0;
        end else begin
            enable      <= enable_n;
            auto_reload <= auto_reload_n;
            irq_en      <= irq_en_n;
            expired     <= expired_n;
            prescale    <= prescale_n;
            pc          <= pc_n;
            reload      <= reload_n;
            count       <= count_n;
            irq         <= irq_n;
        end
    end

    always_comb begin
        bus.data_out = 32'd0;
        if (bus.select && bus.read) begin
            case (bus.address)
                ADDR_CONTROL:  bus.data_out = {23'd0, expired, 5'd0, irq_en, auto_reload, enable};
                ADDR_PRESCALE: bus.data_out = 32'(prescale);
                ADDR_RELOAD:   bus.data_out = reload;
                default:       bus.data_out = count;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// Scoreboarded bench for bus_timer: read data and irq rise cycles are predicted from the timing rules.
module tb_bus_timer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic irq;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    int          irq_q[$];
    logic        irq_prev = 1'b0;

    bus_timer_if bus();

    bus_timer #(.PRESCALE_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or raises irq.
    always @(negedge clock) begin
        if (reset) begin
            irq_prev = 1'b0;
        end else begin
            if (bus.select && bus.read) begin
                if (rd_q.size() == 0) check("unexpected_read", bus.data_out, 32'hxxxx_xxxx);
                else check(rd_name_q.pop_front(), bus.data_out, rd_q.pop_front());
            end else begin
                check("idle_data_out", bus.data_out, 32'd0);
            end
            if (irq && !irq_prev) begin
                if (irq_q.size() == 0) check("unexpected_irq_rise", 32'(cyc), 32'hffff_ffff);
                else check("irq_rise_cycle", 32'(cyc), 32'(irq_q.pop_front()));
            end
            irq_prev = irq;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.select = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.data_in = d; bus.data_strobes = s;
        @(posedge clock);
        #1;
        bus.select = 1'b0; bus.write = 1'b0; bus.data_strobes = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        bus.select = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
        @(posedge clock);
        #1;
        bus.select = 1'b0; bus.read = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!irq && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!irq) begin
            check("irq_timeout", 32'(irq), 32'd1);
            irq_q.delete();
        end
    endtask

    function automatic logic [31:0] merged(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] s);
        logic [31:0] r = 32'd0;
        for (int l = 0; l < 4; l++)
            r = r | ((s[l] ? new_v : old_v) & (32'hFF << (8 * l)));
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, p, r, c, ar, per, nexp;
        logic [31:0] d;
        logic [3:0]  s;

        bus.select = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 2'd0; bus.data_in = 32'd0; bus.data_strobes = 4'd0;
        idle(3);
        reset = 1'b0;
        check("reset_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 4; i++) bus_read(2'(i), 32'd0, "reset_reg");

        // Byte-lane writes and unused-bit readback
        bus_write(2'd2, 32'hDEADBEEF, 4'b0101);
        bus_read(2'd2, 32'h00AD00EF, "reload_strobe");
        bus_write(2'd1, 32'hFFFFFFFF, 4'b1111);
        bus_read(2'd1, 32'h0000FFFF, "prescale_width");
        bus_write(2'd1, 32'd3, 4'b1111);

        // Unselected bus cycle
        bus.select = 1'b0; bus.write = 1'b1; bus.read = 1'b1;
        bus.address = 2'd2; bus.data_in = 32'h12345678; bus.data_strobes = 4'hF;
        idle(1);
        bus.write = 1'b0; bus.read = 1'b0; bus.data_strobes = 4'd0;
        bus_read(2'd2, 32'h00AD00EF, "unselected_write");

        // One-shot: P=3, C=2
        bus_write(2'd3, 32'd2, 4'hF);
        bus_write(2'd0, 32'h5, 4'hF);
        e = cyc;
        irq_q.push_back(e + 12);
        wait_irq(40);
        bus_read(2'd0, 32'h104, "oneshot_control");
        bus_read(2'd3, 32'd0, "oneshot_count");
        idle(10);
        bus_read(2'd3, 32'd0, "oneshot_count_hold");

        // Asynchronous reset while running with irq pending
        bus_write(2'd3, 32'd50, 4'hF);
        bus_write(2'd0, 32'h5, 4'hF);
        check("irq_before_reset", 32'(irq), 32'd1);
        idle(5);
        #3 reset = 1'b1;
        #1 check("irq_async_reset", 32'(irq), 32'd0);
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) bus_read(2'(i), 32'd0, "midrun_reset_reg");
        idle(5);
        bus_read(2'd3, 32'd0, "no_count_after_reset");

        // Auto-reload: P=0, R=4, C=4
        bus_write(2'd2, 32'd4, 4'hF);
        bus_write(2'd3, 32'd4, 4'hF);
        bus_write(2'd0, 32'h7, 4'hF);
        e = cyc;
        for (int i = 1; i <= 3; i++) irq_q.push_back(e + 5 * i);
        for (int i = 0; i < 3; i++) begin
            wait_irq(30);
            bus_write(2'd0, 32'h100, 4'b0010);
        end
        bus_write(2'd0, 32'h100, 4'hF);

        // Set wins: W1C lands on the expiry edge
        bus_write(2'd3, 32'd4, 4'hF);
        bus_write(2'd0, 32'h7, 4'hF);
        e = cyc;
        irq_q.push_back(e + 5);
        idle(4);
        bus_write(2'd0, 32'h100, 4'b0010);
        bus_read(2'd0, 32'h107, "set_wins");
        bus_write(2'd0, 32'h100, 4'hF);
        bus_read(2'd0, 32'h0, "cleared_control");

        // Bus write to COUNT beats the tick; disabling freezes the count
        bus_write(2'd3, 32'd100, 4'hF);
        bus_write(2'd0, 32'h1, 4'hF);
        bus_write(2'd3, 32'h10, 4'hF);
        bus_read(2'd3, 32'h10, "count_write_wins");
        bus_write(2'd0, 32'h0, 4'hF);
        bus_read(2'd3, 32'hE, "count_freeze");
        idle(3);
        bus_read(2'd3, 32'hE, "count_freeze_hold");

        // Disable mid-period, then restart: prescale phase starts over
        bus_write(2'd1, 32'd3, 4'hF);
        bus_write(2'd3, 32'd5, 4'hF);
        bus_write(2'd0, 32'h1, 4'hF);
        idle(5);
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_read(2'd3, 32'd4, "count_after_pause");
        idle(3);
        bus_write(2'd0, 32'h5, 4'hF);
        e = cyc;
        irq_q.push_back(e + 20);
        wait_irq(60);
        bus_write(2'd0, 32'h100, 4'hF);

        // Randomised configurations against the period formulas
        for (int it = 0; it < 12; it++) begin
            p = $urandom_range(0, 3);
            do r = $urandom_range(0, 5); while (p == 0 && r == 0);
            c = $urandom_range(0, 6);
            ar = $urandom_range(0, 1);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            bus_write(2'd2, 32'(r), 4'hF);
            bus_write(2'd2, d, s);
            bus_read(2'd2, merged(32'(r), d, s), "rand_reload_strobe");
            bus_write(2'd2, 32'(r), 4'hF);
            bus_write(2'd1, 32'(p), 4'hF);
            bus_write(2'd3, 32'(c), 4'hF);
            bus_write(2'd0, 32'h5 | 32'(ar << 1), 4'hF);
            e = cyc;
            per = (r + 1) * (p + 1);
            nexp = ar ? 3 : 1;
            irq_q.push_back(e + (c + 1) * (p + 1));
            for (int k = 1; k < nexp; k++) irq_q.push_back(e + (c + 1) * (p + 1) + k * per);
            for (int k = 0; k < nexp; k++) begin
                wait_irq(100);
                if (k < nexp - 1) begin
                    bus_write(2'd0, 32'h100, 4'b0010);
                end else begin
                    if (ar == 0) begin
                        bus_read(2'd0, 32'h104, "rand_oneshot_control");
                        bus_read(2'd3, 32'd0, "rand_oneshot_count");
                    end
                    bus_write(2'd0, 32'h100, 4'hF);
                end
            end
            bus_read(2'd0, 32'h0, "rand_cleared_control");
        end

        idle(3);
        check("irq_queue_drained", 32'(irq_q.size()), 32'd0);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped down-counting timer peripheral on the maxicore32 external bus, downstream of the core's bus interface alongside memory. An external address decoder drives `select`. The core writes the control, prescale, reload and count registers, polls the count or the status flag, and can route `irq` to a pin or LED. Reads and writes complete in a single cycle with no wait states, matching the core's bus timing.

## Interface
- `PRESCALE_WIDTH`, default 16: width of the prescale register and the prescale counter.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `select`  input  1  peripheral selected by the external decoder.
- `address`  input  2  word index, driven from core address bits [3:2].
- `data_in`  input  32  write data from the core.
- `data_out`  output  32  read data to the core.
- `data_strobes`  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
- `read`  input  1  read cycle.
- `write`  input  1  write cycle.
- `irq`  output  1  registered interrupt request; equals `expired & irq_en`.

## Operation
- Register map (word index):
  - 0 CONTROL: bit0 `enable`, bit1 `auto_reload`, bit2 `irq_en`, bit8 `expired`. `expired` is read-only and write-1-to-clear. All other bits read 0.
  - 1 PRESCALE: bits [PRESCALE_WIDTH-1:0] hold P. Upper bits read 0.
  - 2 RELOAD: 32-bit R.
  - 3 COUNT: 32-bit C. Reads return the live count. Writes load C.
- Writes take effect at the rising edge when `select & write`, per strobed byte lane only. Unstrobed lanes keep their value.
  - Bit8 of CONTROL clears `expired` only if lane 1 is strobed and data_in[8]=1.
- Reads: `data_out` is combinational.
  - When `select & read`, it shows the addressed register.
  - Otherwise it is 32'h0.
  - `read` and `write` asserted together: the write is performed and `data_out` shows the pre-write value.
- Prescaler counter `pc`:
  - While `enable`=1, `pc` increments every clock.
  - In a cycle where `pc==P`, a tick occurs and `pc` returns to 0.
  - P=0 gives a tick every clock.
  - `pc` is forced to 0 while `enable`=0 and on any write that sets `enable` from 0 to 1.
- On a tick:
  - If C≠0: C ← C−1.
  - If C==0: `expired` ← 1, then:
    - `auto_reload`=1: C ← R.
    - `auto_reload`=0: `enable` ← 0 and C stays 0 (one-shot).
- Simultaneous events:
  - A bus write to COUNT in a tick cycle wins over the decrement/reload.
  - A bus write to the `enable` bit wins over the one-shot clear.
  - An expiry in the same cycle as a W1C of `expired` leaves `expired`=1 (set wins).
- Writes to PRESCALE or RELOAD while running take effect from the next cycle. `pc` is not reset.
  - If the new P is below the current `pc`, `pc` wraps through 2^PRESCALE_WIDTH−1 before matching.

## Timing
- Reset values: CONTROL=0, PRESCALE=0, RELOAD=0, COUNT=0, `pc`=0, `irq`=0, `data_out`=0 (no read in progress).
- Read latency 0: data is valid in the same cycle as `select & read`. Write latency 1: the value is visible from the edge that samples the write.
- Enable set at edge E with C=N: first expiry sets `expired` at edge E+(N+1)(P+1).
- Auto-reload period thereafter: (R+1)(P+1) clocks.
- `irq` rises at the same edge `expired` sets, when `irq_en`=1. It falls at the edge after a W1C or after `irq_en` is cleared.
- Asynchronous `reset` mid-count clears everything immediately. Counting resumes only after software sets `enable` again.
- Minimum state: roughly 10 flops of control plus 64 of count/reload plus PRESCALE_WIDTH×2 of prescale; no multi-cycle handshakes.

## Test plan
- Reset and readback: assert `reset` mid-run → all four registers read 0 and `irq`=0. Write 32'hDEADBEEF to RELOAD with strobes 4'b0101 → reads 32'h00AD00EF.
- One-shot: P=3, C=2, write CONTROL=32'h5 at edge E → `expired` and `irq` set at edge E+12; CONTROL then reads 32'h104; COUNT holds 0 thereafter.
- Auto-reload: P=0, R=4, C=4, CONTROL=32'h3 → `expired` pulses every 5 clocks. W1C it each time → `expired` sets at E+5, E+10, E+15.
- Set-wins: arrange W1C of CONTROL (data 32'h100, strobes 4'b0010) in the exact expiry cycle → `expired` remains 1.
- Write priority: in a tick cycle, write COUNT=32'h10 → COUNT reads 32'h10, not the decremented value. Clear `enable` mid-count → COUNT freezes and `pc` returns to 0.
- Unselected bus: `read`=1 with `select`=0 → `data_out`=0. `write`=1 with `select`=0 → no register changes.
